// File: rtl/v_priority_request_queue.sv
// v_priority_request_queue
// Collects single-cycle request pulses into a pending set. It issues the
// lowest-index pending request as a 3-bit code on a valid/ready handshake.
// Priority is taken from the registered pending set only, so a code appears
// two edges after its request pulse at the earliest.
module v_priority_request_queue (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] req_in,
  input  logic       flush,
  input  logic       code_ready,
  output logic [2:0] code,
  output logic       code_valid,
  output logic [7:0] pending,
  output logic       overflow,
  output logic [7:0] issue_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] code_reg, code_next;
  logic [7:0] p_reg, p_next;
  logic       overflow_reg, overflow_next;
  logic [7:0] cnt_reg, cnt_next;

  logic [7:0] lowest_onehot;
  logic [2:0] lowest_idx;
  logic       any_pending;
  logic       accept;
  logic       load;
  logic [7:0] clr_mask;

  // A bit is the winner when it is set and no lower-index bit is set.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_prio
      assign lowest_onehot[gi] = p_reg[gi] & ~|(p_reg & ((8'd1 << gi) - 8'd1));
    end
  endgenerate

  // Encode the one-hot winner using the same bit-to-code mapping as the encoder.
  always_comb begin
    lowest_idx = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (lowest_onehot[i]) lowest_idx = lowest_idx | 3'(i);
    end
  end

  assign any_pending = |p_reg;
  assign accept      = (state_reg == FULL) & code_ready;
  // EMPTY refills as soon as something is pending. FULL refills only when the held code is taken.
  assign load        = (state_reg == EMPTY) ? any_pending : code_ready;
  assign clr_mask    = (load & any_pending) ? lowest_onehot : 8'h00;

  // Next-state logic for the pending set, the output stage, the overflow flag and the counter.
  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    // A set and a clear of the same bit in one cycle leave the bit set.
    p_next        = (p_reg & ~clr_mask) | req_in;
    // A re-request of a bit that stays pending merges into it and is flagged.
    overflow_next = overflow_reg | (|(req_in & p_reg & ~clr_mask));
    cnt_next      = cnt_reg + {7'd0, accept};

    if (load) begin
      if (any_pending) begin
        state_next = FULL;
        code_next  = lowest_idx;
      end else begin
        state_next = EMPTY;
        code_next  = 3'b000;
      end
    end

    // Flush drops everything except the transfer count, including this cycle's requests.
    if (flush) begin
      p_next        = 8'h00;
      state_next    = EMPTY;
      code_next     = 3'b000;
      overflow_next = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg    <= EMPTY;
      code_reg     <= 3'b000;
      p_reg        <= 8'h00;
      overflow_reg <= 1'b0;
      cnt_reg      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      p_reg        <= p_next;
      overflow_reg <= overflow_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign code       = code_reg;
  assign code_valid = (state_reg == FULL);
  assign pending    = p_reg;
  assign overflow   = overflow_reg;
  assign issue_cnt  = cnt_reg;

endmodule

// File: tb/tb_v_priority_request_queue.sv
// Directed testbench for v_priority_request_queue with hand-computed expectations.
module tb_v_priority_request_queue;

  logic       clk;
  logic       clr_n;
  logic [7:0] req_in;
  logic       flush;
  logic       code_ready;
  logic [2:0] code;
  logic       code_valid;
  logic [7:0] pending;
  logic       overflow;
  logic [7:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  v_priority_request_queue dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req_in     (req_in),
    .flush      (flush),
    .code_ready (code_ready),
    .code       (code),
    .code_valid (code_valid),
    .pending    (pending),
    .overflow   (overflow),
    .issue_cnt  (issue_cnt)
  );

  // Clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if it has gone far past the expected length.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the whole output stage at once.
  task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic [7:0] n);
    check({tag, ".valid"}, {7'd0, code_valid}, {7'd0, v});
    check({tag, ".code"},  {5'd0, code},       {5'd0, c});
    check({tag, ".pend"},  pending,            p);
    check({tag, ".cnt"},   issue_cnt,          n);
  endtask

  initial begin
    clr_n = 1'b0; req_in = 8'h00; flush = 1'b0; code_ready = 1'b0;
    tick(); tick();
    check_out("reset", 1'b0, 3'd0, 8'h00, 8'd0);
    check("reset.ovf", {7'd0, overflow}, 8'd0);
    clr_n = 1'b1;
    tick();
    check_out("idle", 1'b0, 3'd0, 8'h00, 8'd0);

    // Burst order: the codes appear as 2, 5, 7 back to back.
    code_ready = 1'b1; req_in = 8'hA4;
    tick(); req_in = 8'h00;
    check_out("burst.p", 1'b0, 3'd0, 8'hA4, 8'd0);
    tick(); check_out("burst.c2", 1'b1, 3'd2, 8'hA0, 8'd0);
    tick(); check_out("burst.c5", 1'b1, 3'd5, 8'h80, 8'd1);
    tick(); check_out("burst.c7", 1'b1, 3'd7, 8'h00, 8'd2);
    tick(); check_out("burst.end", 1'b0, 3'd0, 8'h00, 8'd3);
    check("burst.ovf", {7'd0, overflow}, 8'd0);

    // Backpressure: code 2 is held stable for 5 cycles.
    code_ready = 1'b0; req_in = 8'hA4;
    tick(); req_in = 8'h00;
    tick(); check_out("bp.c2", 1'b1, 3'd2, 8'hA0, 8'd3);
    for (int i = 0; i < 4; i++) begin
      tick(); check_out("bp.hold", 1'b1, 3'd2, 8'hA0, 8'd3);
    end
    code_ready = 1'b1;
    tick(); check_out("bp.c5", 1'b1, 3'd5, 8'h80, 8'd4);
    tick(); check_out("bp.c7", 1'b1, 3'd7, 8'h00, 8'd5);
    tick(); check_out("bp.end", 1'b0, 3'd0, 8'h00, 8'd6);

    // Late higher priority: bit 1 arrives while 6 is held and wins over 7.
    code_ready = 1'b0; req_in = 8'hC0;
    tick(); req_in = 8'h00;
    tick(); check_out("late.c6", 1'b1, 3'd6, 8'h80, 8'd6);
    req_in = 8'h02;
    tick(); req_in = 8'h00;
    check_out("late.hold", 1'b1, 3'd6, 8'h82, 8'd6);
    code_ready = 1'b1;
    tick(); check_out("late.c1", 1'b1, 3'd1, 8'h80, 8'd7);
    tick(); check_out("late.c7", 1'b1, 3'd7, 8'h00, 8'd8);
    tick(); check_out("late.end", 1'b0, 3'd0, 8'h00, 8'd9);
    check("late.ovf", {7'd0, overflow}, 8'd0);

    // Overflow/merge: bit 0 occupies the stage while bit 3 is pulsed twice.
    code_ready = 1'b0; req_in = 8'h01;
    tick(); req_in = 8'h08;
    tick(); check("ovf.first", {7'd0, overflow}, 8'd0);
    req_in = 8'h08;
    tick(); req_in = 8'h00;
    check("ovf.set", {7'd0, overflow}, 8'd1);
    check_out("ovf.hold", 1'b1, 3'd0, 8'h08, 8'd9);
    code_ready = 1'b1;
    tick(); check_out("ovf.c3", 1'b1, 3'd3, 8'h00, 8'd10);
    tick(); check_out("ovf.end", 1'b0, 3'd0, 8'h00, 8'd11);
    check("ovf.sticky", {7'd0, overflow}, 8'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("ovf.flushed", {7'd0, overflow}, 8'd0);

    // Re-pulse bit 3 in the cycle it loads: no overflow, and it is issued twice.
    req_in = 8'h08;
    tick(); check_out("rep.p", 1'b0, 3'd0, 8'h08, 8'd11);
    tick(); req_in = 8'h00;
    check_out("rep.c3a", 1'b1, 3'd3, 8'h08, 8'd11);
    check("rep.ovf", {7'd0, overflow}, 8'd0);
    tick(); check_out("rep.c3b", 1'b1, 3'd3, 8'h00, 8'd12);
    tick(); check_out("rep.end", 1'b0, 3'd0, 8'h00, 8'd13);

    // Flush with P=0F and a held code; the request for bit 7 is discarded.
    code_ready = 1'b0; req_in = 8'h0F;
    tick(); req_in = 8'h01;
    tick(); req_in = 8'h02;
    check_out("fl.pre", 1'b1, 3'd0, 8'h0F, 8'd13);
    check("fl.preovf", {7'd0, overflow}, 8'd0);
    tick(); check("fl.ovf", {7'd0, overflow}, 8'd1);
    flush = 1'b1; req_in = 8'h80;
    tick(); flush = 1'b0; req_in = 8'h00;
    check_out("fl.post", 1'b0, 3'd0, 8'h00, 8'd13);
    check("fl.ovfclr", {7'd0, overflow}, 8'd0);
    tick(); check_out("fl.no7", 1'b0, 3'd0, 8'h00, 8'd13);

    // A handshake that coincides with flush still counts.
    req_in = 8'h01;
    tick(); req_in = 8'h00;
    tick(); check_out("flx.c0", 1'b1, 3'd0, 8'h00, 8'd13);
    code_ready = 1'b1; flush = 1'b1;
    tick(); flush = 1'b0;
    check_out("flx.cnt", 1'b0, 3'd0, 8'h00, 8'd14);

    // Counter wrap: after a fresh reset, hold every request high with ready high.
    clr_n = 1'b0; #2;
    check("wrap.rst", issue_cnt, 8'd0);
    clr_n = 1'b1; req_in = 8'hFF; code_ready = 1'b1;
    tick(); tick();
    check_out("wrap.start", 1'b1, 3'd0, 8'hFF, 8'd0);
    for (int i = 0; i < 255; i++) tick();
    check("wrap.255", issue_cnt, 8'd255);
    tick();
    check_out("wrap.0", 1'b1, 3'd0, 8'hFF, 8'd0);

    // Asynchronous reset mid-handshake clears everything at once.
    clr_n = 1'b0; #1;
    check_out("arst", 1'b0, 3'd0, 8'h00, 8'd0);
    check("arst.ovf", {7'd0, overflow}, 8'd0);
    req_in = 8'h00; code_ready = 1'b0;
    tick();
    clr_n = 1'b1;
    tick(); tick(); tick();
    check_out("arst.idle", 1'b0, 3'd0, 8'h00, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
